// File: rtl/bt656_sensor_ctrl.sv
// Purpose : DVP/BT.656 camera sensor power/reset sequencer plus frame-accurate capture gate.
// Latency : VSYNC/HREF edges act 3 clk_i after the pin changes (2-flop sync + edge register); all outputs registered.
// Backpressure: none; the sensor free-runs, and frames that start while not armed are skipped whole.
//
// Ports:
//   clk_i, rst_i            system clock, synchronous active-high reset
//   ctrl_enable_i           1 = power and sequence the sensor, 0 = power it down
//   cap_start_i/cap_stop_i  single-cycle pulses that arm and stop capture
//   cap_continuous_i        sampled with cap_start_i; 1 = keep capturing frames until stopped
//   vsync_i, href_i         asynchronous sensor timing inputs
//   sensor_pwdn_o/rstn_o    sensor power-down (active-high) and reset (active-low) pins
//   sensor_ready_o, busy_o  sequencing complete / capture armed or running
//   cap_en_o                gate to the stream receiver, high only inside a captured frame
//   frame_done_o/err_o      end-of-captured-frame pulse; err flags a line count other than LINES
//   frame_cnt_o, line_cnt_o captured frame count and line count of the last completed frame
module bt656_sensor_ctrl #(
    parameter int PWDN_CYC = 10000,
    parameter int RST_CYC  = 20000,
    parameter int TMR_W    = 20,
    parameter int LINES    = 480,
    parameter int LW       = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ctrl_enable_i,
    input  logic          cap_start_i,
    input  logic          cap_continuous_i,
    input  logic          cap_stop_i,
    input  logic          vsync_i,
    input  logic          href_i,
    output logic          sensor_pwdn_o,
    output logic          sensor_rstn_o,
    output logic          sensor_ready_o,
    output logic          cap_en_o,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          frame_err_o,
    output logic [15:0]   frame_cnt_o,
    output logic [LW-1:0] line_cnt_o
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PWR_WAIT,
        ST_RST_WAIT,
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE
    } state_t;

    // Timers count down to zero, so a load of N-1 gives a state lasting exactly N cycles.
    localparam logic [TMR_W-1:0] PWDN_LOAD = TMR_W'(PWDN_CYC - 1);
    localparam logic [TMR_W-1:0] RST_LOAD  = TMR_W'(RST_CYC - 1);
    localparam logic [LW-1:0]    LINES_LW  = LW'(LINES);
    localparam logic [LW-1:0]    LCNT_MAX  = {LW{1'b1}};

    // ------------------------------------------------------------------
    // State and flops
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Synchronizer chains: bit 0 = s1, bit 1 = s2, bit 2 = history (s3).
    logic [2:0]       vs_sync_q, vs_sync_d;
    logic [2:0]       hr_sync_q, hr_sync_d;

    logic             cont_q, cont_d;
    logic             stop_pend_q, stop_pend_d;
    logic [LW-1:0]    lcnt_q, lcnt_d;

    logic             pwdn_q, pwdn_d;
    logic             rstn_q, rstn_d;
    logic             ready_q, ready_d;
    logic             cap_en_q, cap_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [LW-1:0]    line_cnt_q, line_cnt_d;

    // ------------------------------------------------------------------
    // Edge detection on the synchronized sensor timing
    // ------------------------------------------------------------------
    logic vs_fall;
    logic vs_rise;
    logic hr_rise;

    assign vs_fall = !vs_sync_q[1] &&  vs_sync_q[2];
    assign vs_rise =  vs_sync_q[1] && !vs_sync_q[2];
    assign hr_rise =  hr_sync_q[1] && !hr_sync_q[2];

    // Line counter value including an HREF edge landing in this cycle, saturating.
    logic [LW-1:0] lcnt_inc;
    logic [LW-1:0] lcnt_fin;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        cont_d      = cont_q;
        stop_pend_d = stop_pend_q;
        lcnt_d      = lcnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        line_cnt_d  = line_cnt_q;

        vs_sync_d   = {vs_sync_q[1:0], vsync_i};
        hr_sync_d   = {hr_sync_q[1:0], href_i};

        lcnt_inc    = (lcnt_q == LCNT_MAX) ? lcnt_q : lcnt_q + LW'(1);
        lcnt_fin    = hr_rise ? lcnt_inc : lcnt_q;

        if (!ctrl_enable_i) begin
            // Power-down overrides everything; an in-flight frame is dropped
            // silently and the counters keep their last values.
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_PWR_WAIT;
                    tmr_d   = PWDN_LOAD;
                end
                ST_PWR_WAIT: begin
                    if (tmr_q == '0) begin
                        state_d = ST_RST_WAIT;
                        tmr_d   = RST_LOAD;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_RST_WAIT: begin
                    if (tmr_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_IDLE: begin
                    // A coincident stop cancels the start.
                    if (cap_start_i && !cap_stop_i) begin
                        state_d     = ST_ARM;
                        cont_d      = cap_continuous_i;
                        stop_pend_d = 1'b0;
                    end
                end
                ST_ARM: begin
                    // Only a VSYNC falling edge opens a frame, so arming mid-frame
                    // waits for the following frame rather than capturing a partial one.
                    if (cap_stop_i) begin
                        state_d = ST_IDLE;
                    end else if (vs_fall) begin
                        state_d = ST_CAPTURE;
                        lcnt_d  = '0;
                    end
                end
                ST_CAPTURE: begin
                    lcnt_d = lcnt_fin;
                    if (cap_stop_i) begin
                        stop_pend_d = 1'b1;
                    end
                    if (vs_rise) begin
                        line_cnt_d  = lcnt_fin;
                        done_d      = 1'b1;
                        err_d       = (lcnt_fin != LINES_LW);
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        // A stop arriving on the closing cycle still ends the run.
                        if (cont_q && !stop_pend_q && !cap_stop_i) begin
                            state_d = ST_ARM;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end

        // Level outputs are decoded from the next state so they register
        // together with the state change.
        pwdn_d   = (state_d == ST_OFF);
        rstn_d   = (state_d != ST_OFF) && (state_d != ST_PWR_WAIT);
        ready_d  = (state_d == ST_IDLE) || (state_d == ST_ARM) || (state_d == ST_CAPTURE);
        busy_d   = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
        cap_en_d = (state_d == ST_CAPTURE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_OFF;
            tmr_q       <= '0;
            vs_sync_q   <= '0;
            hr_sync_q   <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            lcnt_q      <= '0;
            pwdn_q      <= 1'b1;
            rstn_q      <= 1'b0;
            ready_q     <= 1'b0;
            cap_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            line_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            vs_sync_q   <= vs_sync_d;
            hr_sync_q   <= hr_sync_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            lcnt_q      <= lcnt_d;
            pwdn_q      <= pwdn_d;
            rstn_q      <= rstn_d;
            ready_q     <= ready_d;
            cap_en_q    <= cap_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

    assign sensor_pwdn_o  = pwdn_q;
    assign sensor_rstn_o  = rstn_q;
    assign sensor_ready_o = ready_q;
    assign cap_en_o       = cap_en_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = done_q;
    assign frame_err_o    = err_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign line_cnt_o     = line_cnt_q;

endmodule
